// File: rtl/md_unit.sv
// E-stage multiply/divide unit owning HI/LO; models multi-cycle latency via a
// countdown and commits the result on the final busy cycle.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [4:0] MULT_LOAD = MULT_CYCLES[4:0];
    localparam logic [4:0] DIV_LOAD  = DIV_CYCLES[4:0];

    state_t      state_r, state_next_s;
    logic [4:0]  cnt_r, cnt_next_s;
    logic [1:0]  op_r;
    logic [31:0] a_r, b_r;
    logic [31:0] hi_r, lo_r, hi_next_s, lo_next_s;
    logic        busy_r;
    logic        accept_s, mt_s, done_s;
    logic [64:0] res_s;

    // Result of a latched op as {valid, hi, lo}; divide by zero yields valid=0.
    function automatic logic [64:0] md_calc(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ax, bx, prod;
        logic        sgn, neg_a, neg_b;
        logic [31:0] mag_a, mag_b, q, r, quot, rem;
        sgn   = ~op[0];
        ax    = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        bx    = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        prod  = ax * bx;
        neg_a = sgn & a[31];
        neg_b = sgn & b[31];
        mag_a = neg_a ? (32'd0 - a) : a;
        mag_b = neg_b ? (32'd0 - b) : b;
        if (mag_b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = mag_a / mag_b;
            r = mag_a % mag_b;
        end
        quot = (neg_a ^ neg_b) ? (32'd0 - q) : q;
        rem  = neg_a ? (32'd0 - r) : r;
        if (op[1] == 1'b0) begin
            md_calc = {1'b1, prod};
        end else if (b == 32'd0) begin
            md_calc = {1'b0, 64'd0};
        end else begin
            md_calc = {1'b1, rem, quot};
        end
    endfunction

    // Next-state, counter and HI/LO update selection.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        hi_next_s    = hi_r;
        lo_next_s    = lo_r;
        accept_s     = (state_r == ST_IDLE) && start && !flush && (md_op <= 3'd3);
        mt_s         = (state_r == ST_IDLE) && start && !flush &&
                       ((md_op == 3'd4) || (md_op == 3'd5));
        done_s       = (state_r == ST_RUN) && !flush && (cnt_r == 5'd1);
        res_s        = md_calc(op_r, a_r, b_r);
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_RUN;
                    cnt_next_s   = md_op[1] ? DIV_LOAD : MULT_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = cnt_r;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = 5'd0;
                end else if (cnt_r == 5'd1) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = 5'd0;
                end else begin
                    state_next_s = ST_RUN;
                    cnt_next_s   = cnt_r - 5'd1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 5'd0;
            end
        endcase
        if (mt_s) begin
            if (md_op[0]) begin
                lo_next_s = rs_data;
            end else begin
                hi_next_s = rs_data;
            end
        end else if (done_s && res_s[64]) begin
            hi_next_s = res_s[63:32];
            lo_next_s = res_s[31:0];
        end else begin
            hi_next_s = hi_r;
            lo_next_s = lo_r;
        end
    end

    // State, counter, operand latch and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 5'd0;
            op_r    <= 2'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            hi_r    <= hi_next_s;
            lo_r    <= lo_next_s;
            busy_r  <= (state_next_s == ST_RUN);
            if (accept_s) begin
                op_r <= md_op[1:0];
                a_r  <= rs_data;
                b_r  <= rt_data;
            end
        end
    end

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

    md_unit_chk u_chk (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy_r)
    );

endmodule

// Protocol checker: the D-stage hazard logic must never issue while busy.
module md_unit_chk (
    input logic clk,
    input logic reset,
    input logic start,
    input logic busy
);
    a_no_start_when_busy: assert property (@(posedge clk) disable iff (reset) !(start && busy))
        else $error("md_unit: start asserted while busy");
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- E-stage multiply/divide unit that owns the HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and models the multi-cycle multiplier/divider latency.
- Drives `busy`, which the D-stage hazard logic ORs into `stall_D` for any mult/div/mfhi/mflo/mthi/mtlo instruction sitting in D.
- Supplies HI/LO values to the mfhi/mflo datapath.

Parameters:
- MULT_CYCLES, 5, cycles `busy` stays high for MULT/MULTU (range 1..31)
- DIV_CYCLES, 10, cycles `busy` stays high for DIV/DIVU (range 1..31)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  E-stage instruction is a valid md op this cycle
- md_op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved
- rs_data  input  32  forwarded rs operand (E stage)
- rt_data  input  32  forwarded rt operand (E stage)
- flush  input  1  exception/flush of the E/M stages; aborts an in-flight op
- busy  output  1  operation in progress; HI/LO not yet valid
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (async, active-high): `busy`=0, `hi`=0, `lo`=0, cycle counter=0, state=IDLE. Reset mid-operation discards the result; HI/LO read 0 afterwards.
- States:
  - IDLE: no operation in flight.
  - RUN: operation in flight, counter active.
- IDLE, start=1, md_op in {0..3}, flush=0:
  - Capture the operands and the op at the clock edge.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - `busy`=1 from the next cycle. Go to RUN.
- IDLE, start=1, md_op=4 (MTHI): `hi`<=rs_data at the clock edge; `busy` stays 0.
- IDLE, start=1, md_op=5 (MTLO): `lo`<=rs_data at the clock edge; `busy` stays 0.
- IDLE, start=1, md_op in {6,7}: ignored.
- RUN:
  - Counter decrements each cycle.
  - On the cycle the counter reaches 1, `hi`/`lo` load the result at that edge, `busy` drops to 0, and the state returns to IDLE.
  - Busy duration is exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
  - The new HI/LO are visible on the same cycle `busy` first reads 0.
- Any start while in RUN is ignored. The hazard logic guarantees this does not occur; an SVA assertion flags it.
- flush=1:
  - In RUN: return to IDLE next edge, `busy`=0, HI/LO unchanged.
  - In IDLE: any same-cycle start is ignored, including MTHI/MTLO.
- Arithmetic:
  - MULT: {hi,lo} = signed(rs) × signed(rt), 64-bit.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend (rs).
  - DIVU: unsigned quotient and remainder.
  - DIV with rs=0x80000000 and rt=0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (rt=0, DIV or DIVU): full DIV_CYCLES busy period; HI/LO unchanged at completion.
- Operands are latched at start. Later changes on rs_data/rt_data during RUN have no effect.
- `hi`/`lo` are registered outputs only; there is no combinational path from the inputs.
- Back-to-back: a start in the first cycle where `busy`=0 after completion is accepted normally.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFE (-2), rt=3 -> `busy` high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> `busy` 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU rs=7, rt=2 -> lo=3, hi=1; then immediately DIVU rt=0 -> busy 10 cycles, hi=1/lo=3 retained.
- MTHI rs=0x12345678, then MTLO rs=0x9ABCDEF0 on consecutive cycles -> `busy` never asserts; hi/lo update on the edge of each start.
- DIV started, flush asserted on busy cycle 4 -> `busy`=0 next cycle, HI/LO hold previous values. Separately, assert reset on busy cycle 3 of a MULT -> outputs 0 immediately (async), no later update.
